// File: rtl/mul_arb_pkg.sv
// Shared types and constants for the mul_arbiter slice.
// The optional pipeline stage is selected with the MUL_ARB_PIPE_EN macro.
package mul_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } mul_arb_state_t;

    localparam int MUL_ARB_NREQ = 2;
    localparam int MUL_ARB_IDW  = 1;

    // Radix-4 Booth digit decode of {b[2j+1], b[2j], b[2j-1]}: returns {neg, two, one}.
    function automatic logic [2:0] booth_decode(input logic [2:0] code);
        logic [2:0] sel;
        case (code)
            3'b001, 3'b010: sel = 3'b001;
            3'b011:         sel = 3'b010;
            3'b100:         sel = 3'b110;
            3'b101, 3'b110: sel = 3'b101;
            default:        sel = 3'b000;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/multiplier.sv
// Combinational signed N x N multiplier: radix-4 Booth recoding, carry-save
// reduction of the partial-product rows, then one carry-propagate add.
module multiplier
    import mul_arb_pkg::*;
#(
    parameter int N = 10
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [2*N:0] p
);

    localparam int W    = 2 * N + 1;
    localparam int ROWS = N / 2;

    logic [W-1:0] a_ext;
    logic [W-1:0] a_ext2;
    logic [N:0]   b_ext;
    logic [2:0]   sel;
    logic [W-1:0] mag;
    logic [W-1:0] pp [ROWS];
    logic [W-1:0] corr;

    always_comb begin
        a_ext  = {{(N + 1){a[N-1]}}, a};
        a_ext2 = a_ext << 1;
        b_ext  = {b, 1'b0};
        corr   = '0;
        sel    = '0;
        mag    = '0;
        // Negative rows are stored inverted; the +1 of each negation lands in corr.
        for (int j = 0; j < ROWS; j++) begin
            sel       = booth_decode(b_ext[2*j +: 3]);
            mag       = sel[1] ? a_ext2 : (sel[0] ? a_ext : '0);
            pp[j]     = (sel[2] ? ~mag : mag) << (2 * j);
            corr[2*j] = sel[2];
        end
    end

    logic [W-1:0] sum_v;
    logic [W-1:0] carry_v;
    logic [W-1:0] carry_n;

    always_comb begin
        sum_v   = pp[0];
        carry_v = corr;
        carry_n = '0;
        for (int j = 1; j < ROWS; j++) begin
            carry_n = ((sum_v & carry_v) | (sum_v & pp[j]) | (carry_v & pp[j])) << 1;
            sum_v   = sum_v ^ carry_v ^ pp[j];
            carry_v = carry_n;
        end
        p = sum_v + carry_v;
    end

endmodule

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; owns last_grant and updates it only on an
// accepted request.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] gnt
);

    logic last_grant_q;
    logic last_grant_d;

    // On a tie the requester that did not win last time is granted.
    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = last_grant_q ? 2'b01 : 2'b10;
        end
    end

    always_comb begin
        last_grant_d = last_grant_q;
        if (accept) begin
            last_grant_d = gnt[1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/mul_arbiter.sv
// Shares one multiplier between two requesters with round-robin arbitration.
// Define MUL_ARB_PIPE_EN to add a stage register after the multiplier (latency 3).
module mul_arbiter
    import mul_arb_pkg::*;
#(
    parameter int N = 10
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [MUL_ARB_NREQ-1:0]   req_valid,
    output logic [MUL_ARB_NREQ-1:0]   req_ready,
    input  logic [MUL_ARB_NREQ*N-1:0] req_a,
    input  logic [MUL_ARB_NREQ*N-1:0] req_b,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic [2*N:0]              res_data,
    output logic [MUL_ARB_IDW-1:0]    res_id
);

    localparam int W = 2 * N + 1;

    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both high; valid never waits on ready, and the sender holds its payload
    // stable while valid is high and ready is low.

    mul_arb_state_t       state_q, state_d;
    logic [N-1:0]         op_a_q, op_a_d;
    logic [N-1:0]         op_b_q, op_b_d;
    logic [MUL_ARB_IDW-1:0] id_q, id_d;
    logic [W-1:0]         res_data_q, res_data_d;
    logic [MUL_ARB_IDW-1:0] res_id_q, res_id_d;
    logic                 res_valid_q, res_valid_d;
`ifdef MUL_ARB_PIPE_EN
    logic [W-1:0]         stage_q, stage_d;
`endif

    logic [1:0]   gnt;
    logic         accept;
    logic [W-1:0] mul_p;

    rr_arb2 u_rr_arb2 (
        .clk    (clk),
        .rst    (rst),
        .req    (req_valid),
        .accept (accept),
        .gnt    (gnt)
    );

    multiplier #(.N(N)) u_multiplier (
        .a (op_a_q),
        .b (op_b_q),
        .p (mul_p)
    );

    assign req_ready = (state_q == IDLE && !rst) ? gnt : 2'b00;
    assign accept    = |(req_valid & req_ready);

    always_comb begin
        state_d     = state_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        id_d        = id_q;
        res_data_d  = res_data_q;
        res_id_d    = res_id_q;
        res_valid_d = res_valid_q;
`ifdef MUL_ARB_PIPE_EN
        stage_d     = stage_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    op_a_d  = gnt[1] ? req_a[N +: N] : req_a[0 +: N];
                    op_b_d  = gnt[1] ? req_b[N +: N] : req_b[0 +: N];
                    id_d    = gnt[1];
                    state_d = CALC;
                end
            end
            CALC: begin
`ifdef MUL_ARB_PIPE_EN
                stage_d     = mul_p;
                state_d     = WAIT;
`else
                res_data_d  = mul_p;
                res_id_d    = id_q;
                res_valid_d = 1'b1;
                state_d     = DONE;
`endif
            end
`ifdef MUL_ARB_PIPE_EN
            WAIT: begin
                res_data_d  = stage_q;
                res_id_d    = id_q;
                res_valid_d = 1'b1;
                state_d     = DONE;
            end
`endif
            DONE: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            op_a_q      <= '0;
            op_b_q      <= '0;
            id_q        <= '0;
            res_data_q  <= '0;
            res_id_q    <= '0;
            res_valid_q <= 1'b0;
`ifdef MUL_ARB_PIPE_EN
            stage_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            id_q        <= id_d;
            res_data_q  <= res_data_d;
            res_id_q    <= res_id_d;
            res_valid_q <= res_valid_d;
`ifdef MUL_ARB_PIPE_EN
            stage_q     <= stage_d;
`endif
        end
    end

    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_id    = res_id_q;

endmodule

// File: tb/tb_mul_arbiter.sv
// Self-checking bench for mul_arbiter: directed vector table, randomized
// traffic against a reference model, reset abort and fairness sequences.
module tb_mul_arbiter;

    localparam int N = 10;
    localparam int W = 2 * N + 1;
`ifdef MUL_ARB_PIPE_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic           clk = 1'b0;
    logic           rst;
    logic [1:0]     req_valid;
    logic [1:0]     req_ready;
    logic [2*N-1:0] req_a;
    logic [2*N-1:0] req_b;
    logic           res_valid;
    logic           res_ready;
    logic [W-1:0]   res_data;
    logic           res_id;

    int checks = 0;
    int errors = 0;
    logic [W:0] exp_q[$];
    logic model_last;

    typedef struct {
        logic [1:0]   v;
        logic [N-1:0] a0;
        logic [N-1:0] b0;
        logic [N-1:0] a1;
        logic [N-1:0] b1;
        int           hold;
        logic [1:0]   gnt;
        logic [W-1:0] data;
        logic         id;
    } vec_t;

    vec_t vecs[9];

    mul_arbiter #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_id    (res_id)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic [1:0] model_grant(input logic [1:0] v, input logic last);
        int winner;
        winner = -1;
        if (v == 2'b11) winner = (last == 1'b1) ? 0 : 1;
        else if (v == 2'b01) winner = 0;
        else if (v == 2'b10) winner = 1;
        if (winner < 0) return 2'b00;
        return 2'(1 << winner);
    endfunction

    function automatic logic [W-1:0] model_mul(input logic [N-1:0] a, input logic [N-1:0] b);
        int ia;
        int ib;
        logic [31:0] prod;
        ia   = $signed(a);
        ib   = $signed(b);
        prod = ia * ib;
        return prod[W-1:0];
    endfunction

    function automatic logic [N-1:0] rand_op();
        int r;
        r = $urandom_range(0, 7);
        if (r == 0) return 10'h200;
        if (r == 1) return 10'h1FF;
        return N'($urandom_range(0, 1023));
    endfunction

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- driver ----------------
    // Called just after a falling edge with the DUT idle; returns on a falling edge.
    task automatic do_txn(input logic [1:0] v, input logic [N-1:0] a0, input logic [N-1:0] b0,
                          input logic [N-1:0] a1, input logic [N-1:0] b1, input int hold,
                          input logic [1:0] exp_gnt, input logic [W-1:0] exp_data,
                          input logic exp_id);
        logic [W:0] e;
        int cyc;
        req_valid = v;
        req_a     = {a1, a0};
        req_b     = {b1, b0};
        res_ready = 1'b0;
        #1;
        check("req_ready_grant", 32'(req_ready), 32'(exp_gnt));
        if (exp_gnt == 2'b00) begin
            @(negedge clk);
            return;
        end
        exp_q.push_back({exp_id, exp_data});
        @(negedge clk);
        req_valid = v & ~exp_gnt;
        cyc = 1;
        while (!res_valid && cyc < 12) begin
            #1;
            check("req_ready_busy", 32'(req_ready), 32'd0);
            @(negedge clk);
            cyc++;
        end
        check("latency", 32'(cyc), 32'(LAT));
        check("res_valid", 32'(res_valid), 32'd1);
        e = exp_q.pop_front();
        repeat (hold) begin
            #1;
            check("hold_data", 32'(res_data), 32'(e[W-1:0]));
            check("hold_id", 32'(res_id), 32'(e[W]));
            check("hold_req_ready", 32'(req_ready), 32'd0);
            @(negedge clk);
        end
        check("res_data", 32'(res_data), 32'(e[W-1:0]));
        check("res_id", 32'(res_id), 32'(e[W]));
        check("res_valid_held", 32'(res_valid), 32'd1);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check("res_valid_drop", 32'(res_valid), 32'd0);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic [1:0]   pv;
        logic [N-1:0] pa[2];
        logic [N-1:0] pb[2];
        logic [1:0]   g;
        logic [W-1:0] d;
        logic [N-1:0] wa;
        logic [N-1:0] wb;

        vecs[0] = '{2'b11, 10'd7,   10'd9,   10'h3FE, 10'd100, 0, 2'b01, 21'd63,      1'b0};
        vecs[1] = '{2'b11, 10'd7,   10'd9,   10'h3FE, 10'd100, 0, 2'b10, 21'h1FFF38,  1'b1};
        vecs[2] = '{2'b01, 10'd3,   10'h3FB, 10'd0,   10'd0,   0, 2'b01, 21'h1FFFF1,  1'b0};
        vecs[3] = '{2'b10, 10'd0,   10'd0,   10'h200, 10'h200, 5, 2'b10, 21'h040000,  1'b1};
        vecs[4] = '{2'b01, 10'h200, 10'h1FF, 10'd0,   10'd0,   2, 2'b01, 21'h1C0200,  1'b0};
        vecs[5] = '{2'b10, 10'd0,   10'd0,   10'd0,   10'h3FF, 0, 2'b10, 21'd0,       1'b1};
        vecs[6] = '{2'b11, 10'h1FF, 10'h1FF, 10'h3FF, 10'h3FF, 0, 2'b01, 21'h03FC01,  1'b0};
        vecs[7] = '{2'b11, 10'h1FF, 10'h1FF, 10'h3FF, 10'h3FF, 1, 2'b10, 21'd1,       1'b1};
        vecs[8] = '{2'b00, 10'd5,   10'd5,   10'd5,   10'd5,   0, 2'b00, 21'd0,       1'b0};

        rst       = 1'b1;
        req_valid = 2'b11;
        req_a     = '0;
        req_b     = '0;
        res_ready = 1'b0;
        model_last = 1'b1;

        @(negedge clk);
        #1;
        check("reset_req_ready", 32'(req_ready), 32'd0);
        check("reset_res_valid", 32'(res_valid), 32'd0);
        check("reset_res_data", 32'(res_data), 32'd0);
        check("reset_res_id", 32'(res_id), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            do_txn(vecs[i].v, vecs[i].a0, vecs[i].b0, vecs[i].a1, vecs[i].b1, vecs[i].hold,
                   vecs[i].gnt, vecs[i].data, vecs[i].id);
            if (vecs[i].gnt != 2'b00) model_last = vecs[i].id;
        end

        // randomized traffic with withdrawals; losers keep their operands stable
        pv = 2'b00;
        pa[0] = '0; pa[1] = '0; pb[0] = '0; pb[1] = '0;
        for (int k = 0; k < 30; k++) begin
            for (int r = 0; r < 2; r++) begin
                if (!pv[r] && $urandom_range(0, 3) != 0) begin
                    pv[r] = 1'b1;
                    pa[r] = rand_op();
                    pb[r] = rand_op();
                end else if (pv[r] && $urandom_range(0, 7) == 0) begin
                    pv[r] = 1'b0;
                end
            end
            g = model_grant(pv, model_last);
            wa = g[1] ? pa[1] : pa[0];
            wb = g[1] ? pb[1] : pb[0];
            d = model_mul(wa, wb);
            do_txn(pv, pa[0], pb[0], pa[1], pb[1], $urandom_range(0, 2), g, d, g[1]);
            if (g != 2'b00) begin
                model_last = g[1];
                pv[g[1]] = 1'b0;
            end
        end

        // reset while the multiplier is in flight
        req_valid = 2'b10;
        req_a = {10'd123, 10'd0};
        req_b = {10'd45, 10'd0};
        #1;
        check("abort_grant", 32'(req_ready), 32'(model_grant(2'b10, model_last)));
        @(negedge clk);
        rst = 1'b1;
        req_valid = 2'b11;
        #1;
        check("req_ready_in_reset", 32'(req_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        req_valid = 2'b00;
        model_last = 1'b1;
        check("abort_res_valid", 32'(res_valid), 32'd0);
        check("abort_res_data", 32'(res_data), 32'd0);
        check("abort_res_id", 32'(res_id), 32'd0);
        repeat (LAT + 1) begin
            @(negedge clk);
            check("no_aborted_result", 32'(res_valid), 32'd0);
        end

        // fairness: both requesters valid continuously, grants alternate from 0
        pa[0] = rand_op(); pb[0] = rand_op();
        pa[1] = rand_op(); pb[1] = rand_op();
        for (int k = 0; k < 10; k++) begin
            g = (k % 2 == 0) ? 2'b01 : 2'b10;
            wa = g[1] ? pa[1] : pa[0];
            wb = g[1] ? pb[1] : pb[0];
            d = model_mul(wa, wb);
            do_txn(2'b11, pa[0], pb[0], pa[1], pb[1], 0, g, d, g[1]);
            model_last = g[1];
            if (g[1]) begin
                pa[1] = rand_op(); pb[1] = rand_op();
            end else begin
                pa[0] = rand_op(); pb[0] = rand_op();
            end
        end

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mul_arbiter.md
# mul_arbiter

Two-port round-robin controller that shares one radix-4 Booth/Dadda `multiplier` instance between two requesters. It registers the granted operands, sequences the combinational multiplier through a small FSM, registers the product, and returns it tagged with the requester ID over a valid/ready handshake. The block sits between the arithmetic consumers and the multiplier datapath, and is the only block that drives the multiplier's operands.

## Interface
Parameters:
- `N`, 10: operand width. Must be even and ≥ 4. Passed unchanged to `multiplier`.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `req_valid`  in  2: per-requester request valid; bit i belongs to requester i.
- `req_ready`  out  2: per-requester grant; at most one bit is high in any cycle.
- `req_a`  in  2×N: packed operand A; `req_a[i]` belongs to requester i. Signed two's complement.
- `req_b`  in  2×N: packed operand B; `req_b[i]` belongs to requester i. Signed two's complement.
- `res_valid`  out  1: a product is available.
- `res_ready`  in  1: the consumer accepts the product.
- `res_data`  out  2N+1: signed product A×B.
- `res_id`  out  1: index of the requester that issued the product.

## Operation
- FSM states: IDLE, CALC, WAIT (present only with the pipeline option), DONE.
- **IDLE:**
  - `req_ready` is asserted for the arbiter winner only.
  - A request is accepted when `req_valid[i]` and `req_ready[i]` are both high. On acceptance, `req_a[i]`, `req_b[i]` and i are captured into the operand and ID registers, and the FSM moves to CALC.
  - With no valid request, the FSM stays in IDLE.
- **CALC:** the multiplier evaluates the registered operands. Its output is written to the result register. Next state is DONE, or WAIT with the pipeline option.
- **WAIT:** the stage register feeds the result register. Next state is DONE.
- **DONE:**
  - `res_valid` is high. `res_data` and `res_id` are held stable until `res_ready` is high.
  - On the handshake, the FSM returns to IDLE.
  - No new request is accepted in DONE. `req_ready` is 0 in every non-IDLE state.
- **Arbitration:**
  - A 1-bit `last_grant` register picks the winner. If both requests are valid, the grant goes to the requester that is not `last_grant`. If only one is valid, that one is granted.
  - `last_grant` updates only on an accepted request.
  - Reset value of `last_grant` is 1, so requester 0 wins the first tie.
- **Arithmetic:**
  - The product is the exact signed value, sign-extended to 2N+1 bits.
  - Extremes are exact: −2^(N−1) × −2^(N−1) = 2^(2N−2).
- **Reset:**
  - Reset in any state aborts the operation in flight, and its result is discarded.
  - After reset: FSM = IDLE, `res_valid` = 0, `res_data` = 0, `res_id` = 0, `req_ready` = 0 for the reset cycle, `last_grant` = 1, operand registers = 0.
- **Protocol rule:** a requester must hold `req_valid`, `req_a` and `req_b` stable until it is granted. Deasserting `req_valid` before the grant withdraws the request, and this is legal.

## Timing
- Acceptance in cycle t puts `res_valid` high from t+2. With `MUL_ARB_PIPE_EN` it is high from t+3.
- Throughput: one product every 3 cycles (4 with the pipeline option) when `res_ready` is tied high. Each cycle `res_ready` is low adds one cycle.
- `req_ready` is decoded combinationally from the state, `req_valid` and `last_grant`. All other outputs come straight from registers.
- The earliest next acceptance is the cycle after the `res_valid`/`res_ready` handshake.

## Configuration
- `MUL_ARB_PIPE_EN` defined:
  - Adds the WAIT state and a (2N+1)-bit stage register between the multiplier output and the result register. This breaks the multiplier's critical path.
  - Latency becomes 3.
- `MUL_ARB_PIPE_EN` undefined:
  - No WAIT state and no stage register.
  - Latency is 2.
- Handshake behaviour is identical in both builds apart from latency.

## Structure
- Package `mul_arb_pkg` holds:
  - the state enum `mul_arb_state_t` (IDLE, CALC, WAIT, DONE);
  - `MUL_ARB_NREQ = 2`;
  - `MUL_ARB_IDW = 1`.
- Sub-module `rr_arb2`: a 2-way round-robin arbiter that owns the `last_grant` register. Inputs are `clk`, `rst`, the request vector and the accept strobe. Output is a one-hot grant.
- `mul_arbiter` instantiates `rr_arb2` and one `multiplier #(.N(N))`.

## Test plan
All scenarios use N=10 unless stated.
- **Single request:** requester 0 with A=3, B=−5, `res_ready`=1 → `res_valid` at t+2, `res_data`=21'h1FFFF1 (−15), `res_id`=0. Repeat with `MUL_ARB_PIPE_EN` → `res_valid` at t+3.
- **Tie after reset:** both requesters valid on the first post-reset cycle (req0: 7×9, req1: −2×100) → req0 granted first and returns 63 with ID 0. Then req1 returns −200 with ID 1. `req_ready` is never 2'b11.
- **Extremes:** −512×−512 → 262144 (21'h040000). −512×511 → −261632. 0×−1 → 0.
- **Backpressure:** `res_ready`=0 for 5 cycles after `res_valid` → `res_data` and `res_id` stay stable, `req_ready`=0 throughout. One cycle after `res_ready` rises, the FSM is in IDLE and accepts the next request.
- **Reset mid-operation:** assert `rst` in CALC → next cycle `res_valid`=0 and the FSM is in IDLE. The aborted product never appears on `res_data`, and the next tie grants requester 0.
- **Fairness:** both requesters valid continuously for 10 products → grants alternate 0,1,0,1…, and every product matches a reference model.
